// File: rtl/alu4_driver.sv
// ============================================================================
// Module   : alu4_driver
// Purpose  : Handshaked front-end that drives a 4-bit combinational ALU,
//            waits a settle time and returns captured results (single/sweep).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu4_driver #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [2:0] req_op,
    input  logic       req_sweep,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_c,
    output logic       alu_cin,
    input  logic [3:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_a,
    output logic [3:0] rsp_b,
    output logic [2:0] rsp_op,
    output logic [3:0] rsp_result,
    output logic       rsp_zero,
    output logic       rsp_overflow,
    output logic       rsp_carry,
    output logic       rsp_last,
    output logic       busy,
    output logic [7:0] rsp_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_sweep;

    assign req_ready = (r_state == IDLE) & ~rst;
    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == RESP);

    // Subtract, compare and equal all run through the adder as a + ~b + 1.
    always_comb begin
        alu_cin = 1'b0;
        case (alu_c)
            3'b001, 3'b110, 3'b111: alu_cin = 1'b1;
            default:                alu_cin = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_sweep      <= 1'b0;
            alu_a        <= 4'd0;
            alu_b        <= 4'd0;
            alu_c        <= 3'd0;
            rsp_a        <= 4'd0;
            rsp_b        <= 4'd0;
            rsp_op       <= 3'd0;
            rsp_result   <= 4'd0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_last     <= 1'b0;
            rsp_count    <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        alu_a   <= req_a;
                        alu_b   <= req_b;
                        alu_c   <= req_op;
                        r_sweep <= req_sweep;
                        r_cnt   <= c_SETTLE_LOAD;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_cnt == 4'd0) begin
                        rsp_a        <= alu_a;
                        rsp_b        <= alu_b;
                        rsp_op       <= alu_c;
                        rsp_result   <= alu_result;
                        rsp_zero     <= alu_zero;
                        rsp_overflow <= alu_overflow;
                        rsp_carry    <= alu_carry;
                        rsp_last     <= ~r_sweep | ((alu_a == 4'hF) & (alu_b == 4'hF));
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_count <= rsp_count + 8'd1;
                        if (rsp_last) begin
                            r_state <= IDLE;
                        end else begin
                            // Sweep walks b fastest, carrying into a.
                            if (alu_b == 4'hF) begin
                                alu_b <= 4'd0;
                                alu_a <= alu_a + 4'd1;
                            end else begin
                                alu_b <= alu_b + 4'd1;
                            end
                            r_cnt   <= c_SETTLE_LOAD;
                            r_state <= DRIVE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu4_driver.sv
// ============================================================================
// Module   : tb_alu4_driver
// Purpose  : Self-checking bench for alu4_driver with a behavioural 4-bit ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu4_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid = 1'b0, req_ready, req_sweep = 1'b0;
    logic [3:0] req_a = 4'd0, req_b = 4'd0;
    logic [2:0] req_op = 3'd0;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_c;
    logic       alu_cin, alu_zero, alu_overflow, alu_carry;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_zero, rsp_overflow, rsp_carry, rsp_last, busy;
    logic [3:0] rsp_a, rsp_b, rsp_result;
    logic [2:0] rsp_op;
    logic [7:0] rsp_count;

    logic       req_valid4 = 1'b0, req_ready4;
    logic [3:0] req_a4 = 4'd0, req_b4 = 4'd0;
    logic [2:0] req_op4 = 3'd0;
    logic [3:0] alu_a4, alu_b4, alu_result4;
    logic [2:0] alu_c4;
    logic       alu_cin4, alu_zero4, alu_overflow4, alu_carry4;
    logic       rsp_valid4, rsp_zero4, rsp_overflow4, rsp_carry4, rsp_last4, busy4;
    logic [3:0] rsp_a4, rsp_b4, rsp_result4;
    logic [2:0] rsp_op4;
    logic [7:0] rsp_count4;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: returns {zero, overflow, carry, result}.
    function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] c, input logic cin);
        logic [3:0] bb;
        logic [4:0] s;
        logic [3:0] r;
        logic       ovf;
        bb  = (c == 3'b001 || c == 3'b110 || c == 3'b111) ? ~b : b;
        s   = {1'b0, a} + {1'b0, bb} + {4'd0, cin};
        ovf = (a[3] == bb[3]) && (s[3] != a[3]);
        case (c)
            3'b010:  r = a | b;
            3'b011:  r = a & b;
            3'b100:  r = a ^ b;
            3'b101:  r = ~a;
            3'b110:  r = {3'd0, s[3] ^ ovf};
            3'b111:  r = {3'd0, s[3:0] == 4'd0};
            default: r = s[3:0];
        endcase
        return {r == 4'd0, ovf, s[4], r};
    endfunction

    assign {alu_zero, alu_overflow, alu_carry, alu_result}     = alu_model(alu_a, alu_b, alu_c, alu_cin);
    assign {alu_zero4, alu_overflow4, alu_carry4, alu_result4} = alu_model(alu_a4, alu_b4, alu_c4, alu_cin4);

    alu4_driver #(.SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_sweep(req_sweep),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rsp_op(rsp_op), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry), .rsp_last(rsp_last),
        .busy(busy), .rsp_count(rsp_count)
    );

    alu4_driver #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_a(req_a4), .req_b(req_b4),
        .req_op(req_op4), .req_sweep(1'b0),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_c(alu_c4), .alu_cin(alu_cin4),
        .alu_result(alu_result4), .alu_zero(alu_zero4), .alu_overflow(alu_overflow4),
        .alu_carry(alu_carry4),
        .rsp_valid(rsp_valid4), .rsp_ready(1'b1), .rsp_a(rsp_a4), .rsp_b(rsp_b4),
        .rsp_op(rsp_op4), .rsp_result(rsp_result4), .rsp_zero(rsp_zero4),
        .rsp_overflow(rsp_overflow4), .rsp_carry(rsp_carry4), .rsp_last(rsp_last4),
        .busy(busy4), .rsp_count(rsp_count4)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       z;
        logic       o;
        logic       c;
        logic       cin;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_single(input vec_t v);
        int lat = 0;
        wait_ready();
        req_a = v.a; req_b = v.b; req_op = v.op; req_sweep = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("alu_operands", {alu_a, alu_b, 1'b0, alu_c}, {v.a, v.b, 1'b0, v.op});
        chk("alu_cin", 32'(alu_cin), 32'(v.cin));
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency_settle1", lat, 1);
        chk("rsp_ab_op", {rsp_a, rsp_b, 1'b0, rsp_op}, {v.a, v.b, 1'b0, v.op});
        chk("rsp_result", 32'(rsp_result), 32'(v.res));
        chk("rsp_flags_zoc", {rsp_zero, rsp_overflow, rsp_carry}, {v.z, v.o, v.c});
        chk("rsp_last_single", 32'(rsp_last), 32'd1);
        @(posedge clk);
        #1 exp_cnt++;
        chk("rsp_count", 32'(rsp_count), 32'(exp_cnt[7:0]));
        chk("idle_after_single", {rsp_valid, busy, req_ready}, 3'b001);
    endtask

    task automatic do_sweep(input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op,
                            input int exp_n);
        logic [3:0] ea, eb, er;
        logic [7:0] cnt0;
        int         n = 0, cyc = 0;
        logic       done = 1'b0;
        ea = a0; eb = b0;
        wait_ready();
        cnt0 = rsp_count;
        req_a = a0; req_b = b0; req_op = op; req_sweep = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; req_sweep = 1'b0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                er = (op == 3'b011) ? (ea & eb) : 4'(ea + eb);
                chk("sweep_ab_op", {rsp_a, rsp_b, 1'b0, rsp_op}, {ea, eb, 1'b0, op});
                chk("sweep_result", 32'(rsp_result), 32'(er));
                chk("sweep_last", 32'(rsp_last), 32'(ea == 4'hF && eb == 4'hF));
                n++;
                done = rsp_last;
                if (eb == 4'hF) ea = ea + 4'd1;
                eb = eb + 4'd1;
            end
        end
        chk("sweep_done", 32'(done), 32'd1);
        chk("sweep_count", n, exp_n);
        @(posedge clk);
        #1 chk("sweep_rsp_count", 32'(rsp_count), 32'(8'(cnt0 + 8'(exp_n))));
        exp_cnt = exp_cnt + exp_n;
        chk("idle_after_sweep", {rsp_valid, busy, req_ready}, 3'b001);
    endtask

    initial begin
        logic [31:0] snap;
        logic        stable;
        int          guard, lat;

        vecs[0] = '{a: 4'h7, b: 4'h9, op: 3'b000, res: 4'h0, z: 1'b1, o: 1'b0, c: 1'b1, cin: 1'b0};
        vecs[1] = '{a: 4'h3, b: 4'h5, op: 3'b001, res: 4'hE, z: 1'b0, o: 1'b0, c: 1'b0, cin: 1'b1};
        vecs[2] = '{a: 4'h8, b: 4'h1, op: 3'b110, res: 4'h1, z: 1'b0, o: 1'b1, c: 1'b1, cin: 1'b1};
        vecs[3] = '{a: 4'h5, b: 4'h5, op: 3'b111, res: 4'h1, z: 1'b0, o: 1'b0, c: 1'b1, cin: 1'b1};
        vecs[4] = '{a: 4'hC, b: 4'h3, op: 3'b011, res: 4'h0, z: 1'b1, o: 1'b0, c: 1'b0, cin: 1'b0};
        vecs[5] = '{a: 4'h6, b: 4'h5, op: 3'b000, res: 4'hB, z: 1'b0, o: 1'b1, c: 1'b0, cin: 1'b0};
        vecs[6] = '{a: 4'hA, b: 4'h5, op: 3'b100, res: 4'hF, z: 1'b0, o: 1'b0, c: 1'b0, cin: 1'b0};
        vecs[7] = '{a: 4'h3, b: 4'h0, op: 3'b101, res: 4'hC, z: 1'b0, o: 1'b0, c: 1'b0, cin: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {req_ready, busy, rsp_valid, alu_a, alu_b, alu_c, alu_cin},
            {1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0});
        chk("reset_rsp", {rsp_a, rsp_b, rsp_op, rsp_result, rsp_last, rsp_count},
            {4'd0, 4'd0, 3'd0, 4'd0, 1'b0, 8'd0});
        rst = 1'b0;
        #1 chk("req_ready_after_release", 32'(req_ready), 32'd1);

        foreach (vecs[i]) do_single(vecs[i]);

        // Back-pressure
        rsp_ready = 1'b0;
        wait_ready();
        req_a = 4'h9; req_b = 4'h4; req_op = 3'b010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(posedge clk);
            #1 guard++;
        end
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        snap = {rsp_a, rsp_b, rsp_op, rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_last, rsp_count};
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if ({rsp_a, rsp_b, rsp_op, rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_last, rsp_count} != snap[28:0]
                || !rsp_valid || req_ready || !busy)
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_result", 32'(rsp_result), 32'hD);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 exp_cnt++;
        chk("bp_release_idle", {rsp_valid, busy, req_ready}, 3'b001);
        chk("bp_rsp_count", 32'(rsp_count), 32'(exp_cnt[7:0]));

        do_sweep(4'hF, 4'hC, 3'b011, 4);
        do_sweep(4'h0, 4'h0, 3'b000, 256);

        // Reset during a sweep while in DRIVE
        wait_ready();
        req_a = 4'h0; req_b = 4'h0; req_op = 3'b000; req_sweep = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; req_sweep = 1'b0;
        repeat (6) @(negedge clk);
        guard = 0;
        while (!(busy && !rsp_valid) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("midsweep_in_drive", {busy, rsp_valid}, 2'b10);
        rst = 1'b1;
        #1;
        chk("midsweep_reset_ctrl", {rsp_valid, busy, req_ready}, 3'b000);
        chk("midsweep_reset_alu", {alu_a, alu_b, alu_c}, 11'd0);
        chk("midsweep_reset_count", 32'(rsp_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        #1 chk("req_ready_after_midsweep", 32'(req_ready), 32'd1);
        do_single(vecs[0]);

        // Longer settle time on the second instance
        @(negedge clk);
        req_a4 = 4'h6; req_b4 = 4'h5; req_op4 = 3'b000; req_valid4 = 1'b1;
        chk("settle4_ready", 32'(req_ready4), 32'd1);
        @(posedge clk);
        #1 req_valid4 = 1'b0;
        lat = 0;
        while (!rsp_valid4 && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency_settle4", lat, 4);
        chk("settle4_result", {rsp_result4, rsp_overflow4, rsp_carry4, rsp_last4}, {4'hB, 1'b1, 1'b0, 1'b1});
        @(posedge clk);
        #1 chk("settle4_count", {rsp_count4, busy4}, {8'd1, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu4_driver.md
# alu4_driver

Sequential front-end that issues operations to the 4-bit combinational ALU and returns captured results. It accepts one request over a valid/ready handshake, drives the ALU operand and opcode ports from registers, and waits a programmable settle time. It then captures result and flags into a response register presented over a second valid/ready handshake. An optional sweep mode walks every operand pair from the requested start point to (15,15) for one opcode, producing one response per pair.

## Interface
- SETTLE_CYCLES, 1: cycles operands are held before capture; legal range 1..15.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept; equals (state==IDLE) & ~rst.
- req_a, req_b  in  4  operands (start point in sweep mode).
- req_op  in  3  ALU function select, 000..111.
- req_sweep  in  1  1 = sweep mode, 0 = single operation.
- alu_a, alu_b  out  4  registered operands to ALU.
- alu_c  out  3  registered opcode to ALU.
- alu_cin  out  1  carry-in to ALU.
- alu_result  in  4  ALU result.
- alu_zero, alu_overflow, alu_carry  in  1  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_a, rsp_b  out  4  operands that produced this response.
- rsp_op  out  3  opcode that produced this response.
- rsp_result  out  4  captured alu_result.
- rsp_zero, rsp_overflow, rsp_carry  out  1  captured flags.
- rsp_last  out  1  final response of the request; always 1 in single mode.
- busy  out  1  state != IDLE.
- rsp_count  out  8  responses handed off since reset; wraps 255->0.

## Operation
- States: IDLE, DRIVE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch req_a/b/op/sweep into alu_a/alu_b/alu_c/sweep register, load settle counter with SETTLE_CYCLES-1, go DRIVE.
- DRIVE: operands stable on alu_*. Counter decrements each cycle. At the edge where counter==0, capture alu_result and flags into rsp_*, copy alu_a/b/c into rsp_a/b/op, set rsp_last, go RESP.
- RESP: rsp_valid=1; all rsp_* held stable until handshake.
  - On rsp_valid&rsp_ready, rsp_count increments.
  - If rsp_last, go IDLE.
  - Else advance operands (b+1; on b==15, b=0 and a+1), reload counter, go DRIVE.
- rsp_last = ~sweep | (alu_a==15 & alu_b==15) at capture.
- alu_cin = 1 when alu_c is 001, 110 or 111 (two's-complement subtract/compare/equal); 0 otherwise. It is combinational from alu_c.
- Requests are never accepted outside IDLE. req_* values are ignored while busy.
- Reset (asynchronous, any state, including mid-sweep): state IDLE, in-flight work discarded.
  - Reset values: all alu_*, rsp_*, rsp_count and busy are 0; rsp_valid=0; req_ready=0 while rst high, 1 on the first cycle after release.

## Timing
- Acceptance edge E0. DRIVE spans SETTLE_CYCLES cycles. Capture at edge E0+SETTLE_CYCLES; rsp_valid is high in the following cycle.
- With SETTLE_CYCLES=1, rsp_valid first rises one cycle after acceptance.
- Single mode, rsp_ready held 1: the response handshake occurs in the first RESP cycle. req_ready returns high the next cycle. Throughput is one request per SETTLE_CYCLES+2 cycles.
- Sweep, rsp_ready held 1: one response per SETTLE_CYCLES+1 cycles.
- A sweep starting at (a,b) produces 256-16a-b responses.
- Back-pressure: rsp_ready low holds RESP indefinitely with no state or output change.
- rsp_count changes only on the handshake edge and is 8-bit modulo.

## Test plan
- Reset, single add a=7,b=9,op=000, SETTLE=1, rsp_ready=1 -> alu_cin=0; rsp_valid one cycle after accept; rsp_result=0, carry=1, zero=1, overflow=0, last=1; rsp_count=1.
- Single sub a=3,b=5,op=001 -> alu_cin=1; rsp_result=1110, carry=0, overflow=0, last=1. Then compare op=110 with a=1000,b=0001 -> rsp_result=0001.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready=0, busy=1. Release -> one handshake, then IDLE.
- Sweep from a=15,b=12, op=011 -> exactly 4 responses, b=12..15; rsp_result=a&b each; rsp_last only on (15,15). Sweep from (0,0) -> 256 responses, rsp_count wraps back to its start value.
- Assert rst mid-sweep in DRIVE -> rsp_valid and busy drop immediately, alu_*=0, rsp_count=0; a new single request after release completes normally.
- SETTLE_CYCLES=4 -> rsp_valid rises exactly 4 cycles after the acceptance edge.
